// File: rtl/wand_bus_pkg.sv
// Shared types and constants for the wired-AND bus transmitter.
// Frame length depends on whether the WAND_TX_PARITY_EN build option is used.
package wand_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic RELEASE   = 1'b1;

  function automatic int frame_bits(input int data_w, input bit parity_en);
    return data_w + 2 + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/wand_bit_timer.sv
// Bit-period counter: runs 0..BIT_CYCLES-1 and flags the last cycle of each bit.
// Held at zero while clr is high so a new frame always starts a fresh period.
module wand_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt_q;

  assign bit_end = !clr && (cnt_q == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wand_bus_tx.sv
// Bit-serial transmitter for an open-drain wired-AND line with arbitration.
// Build option: define WAND_TX_PARITY_EN to insert an even-parity bit before STOP.
module wand_bus_tx
  import wand_bus_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              line_in,
  output logic              line_out,
  output logic              busy,
  output logic              done,
  output logic              arb_lost,
  output logic [DATA_W-1:0] rx_data,
  output tx_state_e         state_dbg
);

`ifdef WAND_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY_EN);
  localparam int POS_W      = $clog2(FRAME_BITS + 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shadow_q, rx_q;
  logic [POS_W-1:0]  pos_q;
  logic              done_q, arb_q;
  logic              bit_end, accept, lost, finish, drive;
`ifdef WAND_TX_PARITY_EN
  logic              par_q;
`endif

  wand_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == IDLE),
    .bit_end (bit_end)
  );

  always_comb begin
    drive = RELEASE;
    unique case (state_q)
      START:  drive = START_LVL;
      DATA:   drive = shreg_q[DATA_W-1];
`ifdef WAND_TX_PARITY_EN
      PARITY: drive = par_q;
`else
      PARITY: drive = RELEASE;
`endif
      STOP:   drive = STOP_LVL;
      default: drive = RELEASE;
    endcase
  end

  // Request handshake: a frame is accepted on any edge where the block is IDLE,
  // start=1 and the bus reads released (line_in=1); start is ignored otherwise.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    // Losing means we released but someone else held the line low at bit end.
    lost    = bit_end && (state_q != IDLE) && (drive == RELEASE) && (line_in == 1'b0);
    unique case (state_q)
      IDLE: begin
        if (start && line_in) begin
          state_d = START;
          accept  = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (lost) begin
          state_d = IDLE;
        end else if (bit_end && (pos_q == POS_W'(DATA_W))) begin
`ifdef WAND_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
        if (lost) state_d = IDLE;
        else if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (lost) begin
          state_d = IDLE;
        end else if (bit_end) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      shadow_q <= '0;
      rx_q     <= '0;
      pos_q    <= '0;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
`ifdef WAND_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      arb_q   <= lost;
      if (accept) begin
        shreg_q <= data_in;
        pos_q   <= '0;
`ifdef WAND_TX_PARITY_EN
        par_q   <= ^data_in;
`endif
      end else if (bit_end && (state_q != IDLE)) begin
        pos_q <= pos_q + POS_W'(1);
        if (state_q == DATA) begin
          shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
          shadow_q <= {shadow_q[DATA_W-2:0], line_in};
        end
      end
      if (finish) rx_q <= shadow_q;
    end
  end

  assign line_out  = drive;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign arb_lost  = arb_q;
  assign rx_data   = rx_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_wand_bus_tx.sv
// Directed, table-driven bench for wand_bus_tx on a modelled wired-AND line.
// Honours WAND_TX_PARITY_EN so the same vectors cover both builds.
module tb_wand_bus_tx;
  import wand_bus_pkg::*;

  localparam int DATA_W = 8;
  localparam int BC     = 4;
`ifdef WAND_TX_PARITY_EN
  localparam int NB       = 11;
  localparam int DONE_CYC = 45;
`else
  localparam int NB       = 10;
  localparam int DONE_CYC = 41;
`endif

  logic              clk = 1'b0;
  logic              rst, start, line_in, line_out, busy, done, arb_lost;
  logic              other_drv, bus_low;
  logic [DATA_W-1:0] data_in, rx_data;
  tx_state_e         state_dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] data;
    bit         other_en;
    logic [7:0] other;
    bit         restart;
    int         ev;
    bit         arb;
    logic [7:0] rx;
  } vec_t;

  vec_t vecs[8];

  // Clock / reset
  always #5 clk = ~clk;

  // Wired-AND resolution of the DUT, a second agent and a stuck-low fault source.
  assign line_in = line_out & other_drv & ~bus_low;

  wand_bus_tx #(.DATA_W(DATA_W), .BIT_CYCLES(BC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .line_in   (line_in),
    .line_out  (line_out),
    .busy      (busy),
    .done      (done),
    .arb_lost  (arb_lost),
    .rx_data   (rx_data),
    .state_dbg (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= DATA_W) return d[DATA_W-b];
`ifdef WAND_TX_PARITY_EN
    if (b == DATA_W + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  // Driver: send one frame from IDLE, optionally against a second agent, and
  // check every cycle up to the done/arb_lost pulse.
  task automatic run_frame(input vec_t v, input string tag);
    int bi;
    data_in   = v.data;
    start     = 1'b1;
    other_drv = 1'b1;
    tick();
    start   = 1'b0;
    data_in = ~v.data;
    for (int c = 1; c <= v.ev; c++) begin
      bi        = (c - 1) / BC;
      other_drv = (v.other_en && bi < NB) ? frame_bit(v.other, bi) : 1'b1;
      if (v.restart) begin
        start   = (c == 10);
        data_in = 8'h00;
      end
      check({tag, " line_out"}, line_out, (c < v.ev) ? frame_bit(v.data, bi) : 1'b1);
      check({tag, " busy"}, busy, (c < v.ev));
      check({tag, " done"}, done, (c == v.ev) && !v.arb);
      check({tag, " arb_lost"}, arb_lost, (c == v.ev) && v.arb);
      if (c < v.ev) tick();
    end
    check({tag, " rx_data"}, rx_data, v.rx);
    start     = 1'b0;
    other_drv = 1'b1;
    tick();
    check({tag, " done_after"}, done, 1'b0);
    check({tag, " arb_after"}, arb_lost, 1'b0);
  endtask

  initial begin
    logic any_bad;
    int   first, second;
    vec_t v;

    //             data   oth  other  rst  ev        arb  rx
    vecs[0] = '{8'hA5, 1'b0, 8'h00, 1'b0, DONE_CYC, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 8'hA4, 1'b0, 37,       1'b1, 8'hA5};
    vecs[2] = '{8'hA4, 1'b1, 8'hA4, 1'b0, DONE_CYC, 1'b0, 8'hA4};
    vecs[3] = '{8'h3C, 1'b1, 8'hA5, 1'b0, 21,       1'b1, 8'hA4};
    vecs[4] = '{8'h5A, 1'b0, 8'h00, 1'b1, DONE_CYC, 1'b0, 8'h5A};
    vecs[5] = '{8'h00, 1'b1, 8'hFF, 1'b0, DONE_CYC, 1'b0, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 8'h00, 1'b0, 9,        1'b1, 8'h00};
    vecs[7] = '{8'h01, 1'b0, 8'h00, 1'b0, DONE_CYC, 1'b0, 8'h01};

    rst       = 1'b1;
    start     = 1'b0;
    data_in   = '0;
    other_drv = 1'b1;
    bus_low   = 1'b0;
    repeat (3) tick();
    check("rst line_out", line_out, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst arb_lost", arb_lost, 1'b0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst state", state_dbg, IDLE);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Bus held low by someone else: requests must be refused.
    bus_low = 1'b1;
    start   = 1'b1;
    data_in = 8'hC3;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("buslow busy", busy, 1'b0);
      check("buslow line_out", line_out, 1'b1);
    end
    start   = 1'b0;
    bus_low = 1'b0;
    tick();

    // Reset in the middle of a 0x3C frame.
    data_in = 8'h3C;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    check("midrst busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst line_out", line_out, 1'b1);
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst arb_lost", arb_lost, 1'b0);
    check("midrst rx_data", rx_data, 8'h00);
    rst     = 1'b0;
    any_bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      any_bad = any_bad | done | arb_lost | ~line_out | busy;
    end
    check("midrst quiet", any_bad, 1'b0);
    v = '{8'h3C, 1'b0, 8'h00, 1'b0, DONE_CYC, 1'b0, 8'h3C};
    run_frame(v, "postrst");

    // start held high: second frame is accepted in the done cycle.
    other_drv = 1'b1;
    data_in   = 8'hFF;
    start     = 1'b1;
    tick();
    data_in = 8'h00;
    first   = 0;
    second  = 0;
    for (int c = 1; c <= 200 && second == 0; c++) begin
      if (done) begin
        if (first == 0) begin
          first = c;
          check("b2b rx_first", rx_data, 8'hFF);
        end else begin
          second = c;
          check("b2b rx_second", rx_data, 8'h00);
        end
      end
      if (first != 0 && c == first + 1) check("b2b second_start", line_out, 1'b0);
      if (second == 0) tick();
    end
    check("b2b first_done_cycle", first, DONE_CYC);
    check("b2b second_done_cycle", second, 2 * DONE_CYC);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("final idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
